// File: rtl/neuron_buffer_ctrl_if.sv
// neuron_buffer_ctrl_if: command, load-stream and row-output handshakes of the
// neuron buffer sequencer. The master side is the scheduler / DMA / convolution
// unit; the slave side is the sequencer itself.
interface neuron_buffer_ctrl_if #(
    parameter int depth = 2,
    parameter int A     = 7,
    parameter int W     = 16
);
    localparam int D = 1 << depth;

    // command channel
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_op;
    logic [A-1:0]     cmd_base;
    logic [A:0]       cmd_rows;

    // load word stream
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;

    // row output stream
    logic             out_valid;
    logic             out_ready;
    logic [W*D-1:0]   out_data;

    modport master (
        output cmd_valid, cmd_op, cmd_base, cmd_rows,
        output in_valid, in_data,
        output out_ready,
        input  cmd_ready, in_ready, out_valid, out_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_base, cmd_rows,
        input  in_valid, in_data,
        input  out_ready,
        output cmd_ready, in_ready, out_valid, out_data
    );
endinterface

// File: rtl/neuron_buffer_ctrl.sv
// neuron_buffer_ctrl: LOAD / READ sequencer for one D-bank, W-bit neuron buffer.
// LOAD streams words into the buffer bank-by-bank, row-by-row through the io
// port; READ sweeps a row range on the wide port with a valid/ready handshake.
// Build option NEURON_BUFFER_CTRL_WRAP_EN: row addresses wrap modulo 2^A, the
// range check is removed and err stays low. Without it, a command whose rows
// run past the top of the buffer is rejected with the sticky err flag.
module neuron_buffer_ctrl #(
    parameter int depth = 2,
    parameter int A     = 7,
    parameter int W     = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    neuron_buffer_ctrl_if.slave       bus,
    output logic [A-1:0]              buf_address,
    output logic                      buf_write,
    output logic [W+depth:0]          buf_io_inputs,
    input  logic [W*(1<<depth)-1:0]   buf_op,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);
    localparam int D = 1 << depth;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_READ = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [A-1:0]     base_r;
    logic [A:0]       rows_r;
    logic [A:0]       row_r;
    logic [depth-1:0] bank_r;
    logic             out_valid_r;
    logic             err_r;

    logic             rows_zero_s;
    logic             range_bad_s;
    logic             load_hs_s;
    logic             read_hs_s;
    logic             last_bank_s;
    logic             last_row_s;
    logic             read_adv_s;
    logic [A:0]       rows_m1_s;

    assign rows_zero_s = (bus.cmd_rows == {(A+1){1'b0}});

`ifdef NEURON_BUFFER_CTRL_WRAP_EN
    assign range_bad_s = 1'b0;
`else
    // One extra guard bit beyond A+1 so base + rows can never overflow the check.
    localparam logic [A+1:0] ADDR_SPAN = {2'b01, {A{1'b0}}};
    logic [A+1:0] range_end_s;
    assign range_end_s = {2'b00, bus.cmd_base} + {1'b0, bus.cmd_rows};
    assign range_bad_s = (range_end_s > ADDR_SPAN);
`endif

    // A word is taken only in LOAD; reset suppresses the write in its own cycle.
    assign load_hs_s   = (state_r == ST_LOAD) & bus.in_valid & ~RST;
    assign read_hs_s   = (state_r == ST_READ) & out_valid_r & bus.out_ready;
    assign last_bank_s = (bank_r == {depth{1'b1}});
    assign rows_m1_s   = rows_r - (A+1)'(1);
    assign last_row_s  = (row_r == rows_m1_s);
    // Step the read address one row early so the next row is ready next cycle.
    assign read_adv_s  = read_hs_s & ~last_row_s;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    if (rows_zero_s || range_bad_s) begin
                        state_s = ST_FIN;
                    end else if (bus.cmd_op) begin
                        state_s = ST_READ;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (load_hs_s && last_bank_s && last_row_s) begin
                    state_s = ST_FIN;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_READ: begin
                if (read_hs_s && last_row_s) begin
                    state_s = ST_FIN;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_FIN:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Command latch, row/bank counters, output-valid and sticky error flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            base_r      <= {A{1'b0}};
            rows_r      <= {(A+1){1'b0}};
            row_r       <= {(A+1){1'b0}};
            bank_r      <= {depth{1'b0}};
            out_valid_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        base_r      <= bus.cmd_base;
                        rows_r      <= bus.cmd_rows;
                        row_r       <= {(A+1){1'b0}};
                        bank_r      <= {depth{1'b0}};
                        out_valid_r <= 1'b0;
                        err_r       <= range_bad_s & ~rows_zero_s;
                    end
                end
                ST_LOAD: begin
                    if (load_hs_s) begin
                        if (last_bank_s) begin
                            bank_r <= {depth{1'b0}};
                            row_r  <= row_r + (A+1)'(1);
                        end else begin
                            bank_r <= bank_r + depth'(1);
                        end
                    end
                end
                ST_READ: begin
                    // out_valid is low only on the entry cycle of READ.
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                    end else if (bus.out_ready) begin
                        if (last_row_s) begin
                            out_valid_r <= 1'b0;
                        end else begin
                            row_r <= row_r + (A+1)'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode: status from state, buffer controls from the live handshakes.
    always_comb begin
        bus.cmd_ready = (state_r == ST_IDLE);
        busy          = (state_r != ST_IDLE);
        done          = (state_r == ST_FIN);
        err           = err_r;
        bus.in_ready  = (state_r == ST_LOAD) & ~RST;
        bus.out_valid = out_valid_r;
        bus.out_data  = buf_op;
        buf_write     = load_hs_s;
        if (load_hs_s) begin
            buf_io_inputs = {bus.in_data, bank_r, 1'b1};
        end else begin
            buf_io_inputs = {(W+depth+1){1'b0}};
        end
        case (state_r)
            ST_LOAD: buf_address = base_r + row_r[A-1:0];
            ST_READ: buf_address = base_r + row_r[A-1:0] + A'(read_adv_s);
            default: buf_address = {A{1'b0}};
        endcase
    end
endmodule

// File: tb/tb_neuron_buffer_ctrl.sv
// tb_neuron_buffer_ctrl: directed plus randomized commands against a
// buffer model and a row-level reference memory of expected contents.
module tb_neuron_buffer_ctrl;
    localparam int depth = 2;
    localparam int A     = 7;
    localparam int W     = 16;
    localparam int D     = 4;
    localparam int NROW  = 128;
`ifdef NEURON_BUFFER_CTRL_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RST;
    logic [A-1:0]     buf_address;
    logic             buf_write;
    logic [W+depth:0] buf_io_inputs;
    logic [W*D-1:0]   buf_op;
    logic             busy;
    logic             done;
    logic             err;
    logic             mem_clr;

    neuron_buffer_ctrl_if #(.depth(depth), .A(A), .W(W)) bus ();

    neuron_buffer_ctrl #(.depth(depth), .A(A), .W(W)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .bus           (bus),
        .buf_address   (buf_address),
        .buf_write     (buf_write),
        .buf_io_inputs (buf_io_inputs),
        .buf_op        (buf_op),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 CLK = ~CLK;

    logic [W*D-1:0] buf_mem [NROW];
    logic [W*D-1:0] ref_mem [NROW];
    logic [W-1:0]   wdata   [64];

    int checks = 0;
    int errors = 0;

    // Buffer instance model: banked io-port write, 1-cycle registered wide read.
    always @(posedge CLK) begin
        if (mem_clr) begin
            for (int i = 0; i < NROW; i++) buf_mem[i] <= '0;
        end else if (buf_write && buf_io_inputs[0]) begin
            buf_mem[buf_address][buf_io_inputs[depth:1]*W +: W] <= buf_io_inputs[W+depth:depth+1];
        end
        buf_op <= buf_mem[buf_address];
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // per-command model state
    int c_base, c_rows, cyc, k_words, k_rows, last_hs_cyc, done_cyc, done_cnt, first_ov_cyc;
    bit load_act, read_act, prev_stall, err_at_done;
    logic [W*D-1:0] prev_data;

    task automatic monitor();
        int ea;
        int eb;
        if (cyc == 0) begin
            check_val("cmd_ready_idle", bus.cmd_ready, 1);
            check_val("busy_idle", busy, 0);
        end
        check_val("in_ready", bus.in_ready, load_act);
        check_val("buf_write", buf_write, load_act && bus.in_valid);
        check_val("io_select", buf_io_inputs[0], load_act && bus.in_valid);
        if (load_act && bus.in_valid) begin
            ea = (c_base + k_words / D) % NROW;
            eb = k_words % D;
            check_val("wr_addr", buf_address, ea);
            check_val("wr_bank", buf_io_inputs[depth:1], eb);
            check_val("wr_data", buf_io_inputs[W+depth:depth+1], bus.in_data);
            ref_mem[ea][eb*W +: W] = bus.in_data;
            k_words++;
            last_hs_cyc = cyc;
            if (k_words == c_rows * D) load_act = 1'b0;
        end
        if (read_act && cyc == 1) check_val("rd_entry_addr", buf_address, c_base % NROW);
        if (!read_act) check_val("out_valid_off", bus.out_valid, 0);
        if (prev_stall) begin
            check_val("stall_valid", bus.out_valid, 1);
            check_val("stall_data", bus.out_data, prev_data);
        end
        if (read_act && bus.out_valid) begin
            if (first_ov_cyc < 0) first_ov_cyc = cyc;
            ea = (c_base + k_rows + ((bus.out_ready && k_rows != c_rows - 1) ? 1 : 0)) % NROW;
            check_val("rd_addr", buf_address, ea);
            if (bus.out_ready) begin
                check_val("rd_data", bus.out_data, ref_mem[(c_base + k_rows) % NROW]);
                k_rows++;
                last_hs_cyc = cyc;
                if (k_rows == c_rows) read_act = 1'b0;
            end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        if (done) begin
            done_cnt++;
            if (done_cyc < 0) begin
                done_cyc    = cyc;
                err_at_done = err;
            end
            check_val("cmd_ready_fin", bus.cmd_ready, 0);
        end
    endtask

    task automatic step();
        @(negedge CLK);
        monitor();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_cmd_ready"}, bus.cmd_ready, 1);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_err"}, err, 0);
        check_val({tag, "_in_ready"}, bus.in_ready, 0);
        check_val({tag, "_out_valid"}, bus.out_valid, 0);
        check_val({tag, "_buf_write"}, buf_write, 0);
        check_val({tag, "_io_inputs"}, buf_io_inputs, 0);
        check_val({tag, "_address"}, buf_address, 0);
    endtask

    // mode: 0 = in_valid/out_ready held high, 1 = gaps / pattern 1,0,0,1,1, 2 = random
    task automatic do_cmd(input bit op, input int base, input int rows, input int mode,
                          input int abort_at, input bit seq);
        bit bad;
        int total;
        int exp_done;
        int idx;
        int pat [5] = '{1, 0, 0, 1, 1};
        bad   = !WRAP && rows != 0 && (base + rows > NROW);
        total = rows * D;
        for (int i = 0; i < 64; i++) wdata[i] = seq ? W'(i + 1) : W'($urandom);
        c_base = base; c_rows = rows; k_words = 0; k_rows = 0;
        last_hs_cyc = -1; done_cyc = -1; done_cnt = 0; first_ov_cyc = -1;
        prev_stall = 1'b0; load_act = 1'b0; read_act = 1'b0; err_at_done = 1'b0; cyc = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_base  = base[A-1:0];
        bus.cmd_rows  = rows[A:0];
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        step();
        bus.cmd_valid = 1'b0;
        bus.cmd_base  = A'($urandom);
        bus.cmd_rows  = (A+1)'($urandom);
        if (!bad && rows > 0) begin
            load_act = !op;
            read_act = op;
        end
        cyc = 1;
        while (cyc < 200 && done_cyc < 0) begin
            if (abort_at >= 0 && k_words == abort_at) begin
                load_act = 1'b0;
                RST = 1'b1;
                bus.in_valid = 1'b1;
                bus.in_data  = 16'hdead;
                step();
                RST = 1'b0;
                bus.in_valid = 1'b0;
                check_reset_outputs("abort");
                return;
            end
            if (!op) begin
                case (mode)
                    0:       bus.in_valid = 1'b1;
                    1:       bus.in_valid = cyc[0];
                    default: bus.in_valid = $urandom_range(0, 1);
                endcase
                bus.in_data = (k_words < total) ? wdata[k_words] : W'($urandom);
            end else begin
                bus.in_valid = $urandom_range(0, 1);
                bus.in_data  = W'($urandom);
            end
            idx = cyc - 2;
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (idx >= 0 && idx < 5) ? pat[idx][0] : 1'b1;
                default: bus.out_ready = $urandom_range(0, 1);
            endcase
            step();
            cyc++;
        end
        bus.in_valid = 1'b0;
        check_val("done_seen", done_cyc >= 0, 1);
        exp_done = (bad || rows == 0) ? 1 : last_hs_cyc + 1;
        check_val("done_cycle", done_cyc, exp_done);
        check_val("err_flag", err_at_done, bad);
        if (op) check_val("rows_read", k_rows, (bad || rows == 0) ? 0 : rows);
        else    check_val("words_loaded", k_words, (bad || rows == 0) ? 0 : total);
        if (op && !bad && rows > 0) check_val("first_out_valid", first_ov_cyc, 2);
        step();
        check_val("done_pulse", done_cnt, 1);
        check_val("cmd_ready_back", bus.cmd_ready, 1);
        check_val("busy_back", busy, 0);
    endtask

    initial begin
        RST = 1'b1;
        mem_clr = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = 1'b0; bus.cmd_base = '0; bus.cmd_rows = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        for (int i = 0; i < NROW; i++) ref_mem[i] = '0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        mem_clr = 1'b0;
        check_reset_outputs("reset");

        do_cmd(1'b0, 5, 2, 0, -1, 1'b1);
        check_val("mem_row5", buf_mem[5], 64'h0004_0003_0002_0001);
        check_val("mem_row6", buf_mem[6], 64'h0008_0007_0006_0005);
        do_cmd(1'b1, 5, 2, 0, -1, 1'b0);
        do_cmd(1'b1, 4, 3, 1, -1, 1'b0);
        do_cmd(1'b0, 5, 2, 1, -1, 1'b1);
        check_val("mem_row5_gap", buf_mem[5], 64'h0004_0003_0002_0001);
        check_val("mem_row6_gap", buf_mem[6], 64'h0008_0007_0006_0005);
        do_cmd(1'b0, 127, 2, 2, -1, 1'b0);
        do_cmd(1'b1, 127, 2, 0, -1, 1'b0);
        do_cmd(1'b1, 30, 0, 0, -1, 1'b0);
        do_cmd(1'b0, 20, 2, 0, 3, 1'b0);
        do_cmd(1'b1, 20, 1, 0, -1, 1'b0);

        for (int n = 0; n < 30; n++) begin
            int b;
            b = ($urandom_range(0, 3) == 0) ? 124 + $urandom_range(0, 3) : $urandom_range(0, NROW - 1);
            do_cmd(1'(  $urandom_range(0, 1)), b, $urandom_range(0, 5), $urandom_range(0, 2), -1, 1'b0);
        end

        for (int i = 0; i < NROW; i++) check_val("mem_final", buf_mem[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
